// File: rtl/genie_split_pkg.sv
// Shared helpers for the GENIE multicast splitter.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package genie_split_pkg;

    // Pointer width for a DEPTH-entry store; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/genie_fifo_mem.sv
// Storage array for the splitter FIFO: registered write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner decides when to write.
module genie_fifo_mem
    import genie_split_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int EW    = 34,
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only the owner's pointers are.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/genie_split_buf.sv
// Buffered multicast splitter: FIFO of {data, mask}, head word lazily forked to N outputs.
// Latency: 1 cycle from accepted push to outputs; no fall-through.
// Backpressure: o_ready = !full from flops only; no path from any i_ready to o_ready.
module genie_split_buf
    import genie_split_pkg::*;
#(
    parameter int N     = 2,
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_valid,
    input  logic [N-1:0]               i_mask,
    output logic                       o_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [N-1:0]               o_valid,
    input  logic [N-1:0]               i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int EW = WIDTH + N;
    localparam int PW = clog2_min1(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("genie_split_buf: DEPTH must be a power of two and at least 2");
        end
        if (N < 1 || WIDTH < 1) begin : g_bad_size
            $error("genie_split_buf: N and WIDTH must be at least 1");
        end
    endgenerate

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [N-1:0]     done;

    logic [EW-1:0]    head;
    logic [N-1:0]     head_mask;
    logic [WIDTH-1:0] head_data;
    logic [N-1:0]     pend;
    logic             non_empty;
    logic             full;
    logic             push;
    logic             pop;

    genie_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({i_data, i_mask}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_mask = head[N-1:0];
    assign head_data = head[N +: WIDTH];

    assign non_empty = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign o_ready   = !full;
    assign push      = i_valid & o_ready;

    // Fork/pop decision: an output is pending until it has taken the head word;
    // the head retires once every pending output is either done or taking it now.
    always_comb begin
        pend    = head_mask & ~done;
        o_valid = non_empty ? pend : '0;
        pop     = non_empty & (&(~pend | i_ready));
    end

    assign o_data  = head_data;
    assign o_level = level;

    // Pointer and occupancy tracking; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Remember which outputs already took the current head so none sees it twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= '0;
        end else if (pop) begin
            done <= '0;
        end else begin
            done <= done | (o_valid & i_ready);
        end
    end

endmodule

// File: tb/tb_genie_split_buf.sv
// Self-checking bench for genie_split_buf (N=4, WIDTH=32, DEPTH=4).
// Latency: n/a.
// Backpressure: exercised with directed and random per-output ready.
module tb_genie_split_buf;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic [N-1:0]     i_mask;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [N-1:0]     o_valid;
    logic [N-1:0]     i_ready;
    logic [LW-1:0]    o_level;

    genie_split_buf #(
        .N     (N),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_mask  (i_mask),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered {data, mask} words, set of outputs
    // that already took the head, and per-output queues of words still owed.
    logic [WIDTH+N-1:0] mq [$];
    logic [N-1:0]       mdone;
    logic [WIDTH-1:0]   outq [N][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the edge, then compare outputs mid-cycle.
    task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                         input logic [N-1:0] m, input logic [N-1:0] r);
        logic [N-1:0] ev;
        i_valid = v;
        i_data  = d;
        i_mask  = m;
        i_ready = r;
        #4;
        ev = (mq.size() != 0) ? (mq[0][N-1:0] & ~mdone) : '0;
        chk("level", 64'(o_level), 64'(mq.size()));
        chk("ready", 64'(o_ready), 64'(mq.size() < DEPTH));
        chk("valid", 64'(o_valid), 64'(ev));
        if (ev != '0) begin
            chk("data", 64'(o_data), 64'(mq[0][WIDTH+N-1:N]));
        end
        chk("level_bound", 64'(o_level <= DEPTH), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (o_valid[i] && r[i]) begin
                if (outq[i].size() == 0) begin
                    chk($sformatf("spurious_xfer%0d", i), 64'(o_valid[i]), 64'd0);
                end else begin
                    chk($sformatf("stream%0d", i), 64'(o_data), 64'(outq[i].pop_front()));
                end
            end
        end
    endtask

    // Advance the model by one clock using the currently applied inputs, then clock.
    task automatic tick();
        logic [N-1:0] ev;
        logic         acc;
        acc = i_valid && (mq.size() < DEPTH);
        if (mq.size() != 0) begin
            ev = mq[0][N-1:0] & ~mdone;
            if ((ev & ~i_ready) == '0) begin
                void'(mq.pop_front());
                mdone = '0;
            end else begin
                mdone = mdone | (ev & i_ready);
            end
        end
        if (acc) begin
            mq.push_back({i_data, i_mask});
            for (int i = 0; i < N; i++) begin
                if (i_mask[i]) outq[i].push_back(i_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        mq.delete();
        mdone = '0;
        for (int i = 0; i < N; i++) outq[i].delete();
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_mask  = '0;
        i_ready = '0;
        mdone   = '0;
        #2;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_level", 64'(o_level), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Broadcast to all outputs, popped in its first presented cycle.
        drive(1'b1, 32'hA, 4'b1111, 4'b1111); tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b1111);
        chk("bc_valid", 64'(o_valid), 64'hF);
        chk("bc_data", 64'(o_data), 64'hA);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("bc_level", 64'(o_level), 64'd0);
        tick();

        // Lazy fork: output 0 takes it first, the rest two cycles later.
        drive(1'b1, 32'hB, 4'b0111, 4'b0000); tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0001);
        chk("lf_c1", 64'(o_valid), 64'b0111);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0001);
        chk("lf_c2", 64'(o_valid), 64'b0110);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0110);
        chk("lf_c3", 64'(o_valid), 64'b0110);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("lf_level", 64'(o_level), 64'd0);
        chk("lf_idle", 64'(o_valid), 64'd0);
        tick();

        // Full: four accepted, fifth held until the first pop frees a slot.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + 32'(k), 4'b1111, 4'b0000); tick();
        end
        drive(1'b1, 32'h104, 4'b1111, 4'b0000);
        chk("full_ready", 64'(o_ready), 64'd0);
        chk("full_level", 64'(o_level), 64'd4);
        tick();
        drive(1'b1, 32'h104, 4'b1111, 4'b1111);
        chk("full_pop_ready", 64'(o_ready), 64'd0);
        tick();
        drive(1'b1, 32'h104, 4'b1111, 4'b1111);
        chk("full_ready_rise", 64'(o_ready), 64'd1);
        chk("full_level_after", 64'(o_level), 64'd3);
        tick();
        repeat (6) begin
            drive(1'b0, 32'h0, 4'b0000, 4'b1111); tick();
        end

        // Zero-mask word is discarded; the next word follows one cycle later.
        drive(1'b1, 32'hC, 4'b0000, 4'b0000); tick();
        drive(1'b1, 32'hD, 4'b1000, 4'b0000);
        chk("zm_no_valid", 64'(o_valid), 64'd0);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("zm_valid", 64'(o_valid), 64'b1000);
        chk("zm_data", 64'(o_data), 64'hD);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b1111); tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("zm_level", 64'(o_level), 64'd0);
        tick();

        // Random traffic: masks, valids and readies all randomized.
        repeat (300) begin
            drive(1'($urandom), $urandom, 4'($urandom), 4'($urandom)); tick();
        end
        for (int k = 0; k < 20 && mq.size() != 0; k++) begin
            drive(1'b0, 32'h0, 4'b0000, 4'b1111); tick();
        end
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("drain_level", 64'(o_level), 64'd0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stream%0d_owed", i), 64'(outq[i].size()), 64'd0);
        end
        tick();

        // Reset in the middle of a partially forked word.
        drive(1'b1, 32'h201, 4'b1111, 4'b0000); tick();
        drive(1'b1, 32'h202, 4'b1111, 4'b0011); tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("pre_rst_valid", 64'(o_valid), 64'b1100);
        chk("pre_rst_level", 64'(o_level), 64'd2);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_level", 64'(o_level), 64'd0);
        flush_model();
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        chk("post_rst_ready", 64'(o_ready), 64'd1);
        tick();
        drive(1'b1, 32'h300, 4'b1111, 4'b1111); tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b1111);
        chk("post_rst_valid", 64'(o_valid), 64'hF);
        chk("post_rst_data", 64'(o_data), 64'h300);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 4'b0000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
